// File: rtl/dmem_bus_master_if.sv
// -----------------------------------------------------------------------------
// dmem_bus_master_if
//   Control side of the external data-memory bus between the MEM-stage bus
//   master and the memory responder. The bidirectional data bus DDT is kept
//   as a plain inout net on the master so that tri-state resolution stays a
//   simple net-level affair.
//
//   Signals:
//     DAD     data address                        (master -> slave)
//     MREQ    memory request                      (master -> slave)
//     WRITE   1 = store cycle                     (master -> slave)
//     SIZE    00 word, 01 half, 10 byte, 11 word  (master -> slave)
//     ACKD_n  access acknowledge, active-low      (slave  -> master)
// -----------------------------------------------------------------------------
interface dmem_bus_master_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] DAD;
    logic                  MREQ;
    logic                  WRITE;
    logic [1:0]            SIZE;
    logic                  ACKD_n;

    modport master (
        output DAD,
        output MREQ,
        output WRITE,
        output SIZE,
        input  ACKD_n
    );

    modport slave (
        input  DAD,
        input  MREQ,
        input  WRITE,
        input  SIZE,
        output ACKD_n
    );
endinterface

// File: rtl/dmem_bus_master.sv
// -----------------------------------------------------------------------------
// dmem_bus_master
//   Data-side bus initiator of the MEM stage. Turns one load/store request
//   into a DAD/MREQ/WRITE/SIZE/DDT access, waits for ACKD_n, and returns
//   sign- or zero-extended load data with a one-cycle resp_valid pulse.
//   The pipeline is stalled until the response cycle.
//
//   Ports:
//     clk           clock, rising edge
//     rst           asynchronous reset, active-low
//     req_valid     MEM stage has an access (held stable while stall=1)
//     req_write     1 = store, 0 = load
//     req_size      00 word, 01 half, 10 byte, 11 word
//     req_unsigned  zero-extend loads when 1
//     req_addr      byte address, passed to DAD verbatim
//     req_wdata     right-aligned store data
//     stall         freeze the pipeline (combinational)
//     resp_valid    one-cycle completion pulse
//     resp_rdata    extended load data (0 for stores / aborts)
//     resp_err      timeout abort flag (always 0 without DMEM_TIMEOUT_EN)
//     bus           DAD/MREQ/WRITE/SIZE/ACKD_n (master modport)
//     DDT           bidirectional data bus, driven only during a store access
//
//   Build option:
//     DMEM_TIMEOUT_EN  when defined, an access with no ACKD_n for
//                      TIMEOUT_CYCLES BUSY cycles is aborted with resp_err=1.
// -----------------------------------------------------------------------------
module dmem_bus_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  stall,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    dmem_bus_master_if.master     bus,
    inout  wire  [DATA_WIDTH-1:0] DDT
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                state_q,  state_d;
    logic [ADDR_WIDTH-1:0] dad_q,    dad_d;
    logic                  mreq_q,   mreq_d;
    logic                  write_q,  write_d;
    logic [1:0]            size_q,   size_d;
    logic                  uns_q,    uns_d;
    logic [DATA_WIDTH-1:0] wdata_q,  wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q,  rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic                  timeout;

    // The responder already places bytes/halves in the low lanes, so
    // extension only ever looks at DDT[15:0] or DDT[7:0].
    function automatic logic [DATA_WIDTH-1:0] load_extend(
        input logic [DATA_WIDTH-1:0] raw,
        input logic [1:0]            size,
        input logic                  uns
    );
        logic [DATA_WIDTH-1:0] ext;
        case (size)
            2'b01:   ext = {{(DATA_WIDTH-16){~uns & raw[15]}}, raw[15:0]};
            2'b10:   ext = {{(DATA_WIDTH-8){~uns & raw[7]}}, raw[7:0]};
            default: ext = raw;
        endcase
        return ext;
    endfunction

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // cnt_q holds the number of BUSY cycles already completed, so this is
    // true during the TIMEOUT_CYCLES-th BUSY cycle.
    assign timeout  = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign resp_err = err_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign timeout            = 1'b0;
    assign resp_err           = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        dad_d    = dad_q;
        mreq_d   = mreq_q;
        write_d  = write_q;
        size_d   = size_q;
        uns_d    = uns_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
`ifdef DMEM_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = BUSY;
                    dad_d   = req_addr;
                    size_d  = req_size;
                    write_d = req_write;
                    uns_d   = req_unsigned;
                    wdata_d = req_wdata;
                    mreq_d  = 1'b1;
`ifdef DMEM_TIMEOUT_EN
                    cnt_d   = '0;
                    err_d   = 1'b0;
`endif
                end
            end
            BUSY: begin
`ifdef DMEM_TIMEOUT_EN
                cnt_d = cnt_q + 1'b1;
`endif
                // An ack on the timeout edge takes priority over the abort.
                if (!bus.ACKD_n) begin
                    state_d  = RESP;
                    mreq_d   = 1'b0;
                    write_d  = 1'b0;
                    rvalid_d = 1'b1;
                    rdata_d  = write_q ? '0 : load_extend(DDT, size_q, uns_q);
                end else if (timeout) begin
                    state_d  = RESP;
                    mreq_d   = 1'b0;
                    write_d  = 1'b0;
                    rvalid_d = 1'b1;
                    rdata_d  = '0;
`ifdef DMEM_TIMEOUT_EN
                    err_d    = 1'b1;
`endif
                end
            end
            // A req_valid still high here is the request just served.
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            dad_q    <= '0;
            mreq_q   <= 1'b0;
            write_q  <= 1'b0;
            size_q   <= 2'b00;
            uns_q    <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
            cnt_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            dad_q    <= dad_d;
            mreq_q   <= mreq_d;
            write_q  <= write_d;
            size_q   <= size_d;
            uns_q    <= uns_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
`ifdef DMEM_TIMEOUT_EN
            cnt_q    <= cnt_d;
            err_q    <= err_d;
`endif
        end
    end

    // WRITE is only ever high while MREQ is, so the bus is released on the
    // same edge MREQ falls and is never driven during a load.
    assign DDT        = (mreq_q && write_q) ? wdata_q : {DATA_WIDTH{1'bz}};

    assign bus.DAD    = dad_q;
    assign bus.MREQ   = mreq_q;
    assign bus.WRITE  = write_q;
    assign bus.SIZE   = size_q;

    assign stall      = req_valid && (state_q != RESP);
    assign resp_valid = rvalid_q;
    assign resp_rdata = rdata_q;

endmodule
